// File: rtl/sys_pkg.sv
// Shared definitions for the job scheduler: FSM states, default engine
// lengths and descriptor field layout within a requester's descriptor slice.
package sys_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_COMPLETE  = 3'd4
  } sched_state_e;

  localparam int DEF_STREAM_LEN = 8;
  localparam int DEF_FLUSH_LEN  = 8;
  localparam int DEF_TILE_COUNT = 1;

  // Field positions in units of LEN_W: {tile_count, flush_len, stream_len}
  localparam int DESC_FIELDS     = 3;
  localparam int DESC_STREAM_OFS = 0;
  localparam int DESC_FLUSH_OFS  = 1;
  localparam int DESC_TILE_OFS   = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: first asserted request at or after ptr, with wrap.
// Purely combinational so callers can present it as a same-cycle ready.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic             found_s;
  logic [PTR_W-1:0] idx_s;

  // Scan from ptr upward; the first hit owns the grant.
  always_comb begin
    grant   = {N{1'b0}};
    found_s = 1'b0;
    idx_s   = {PTR_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      idx_s = PTR_W'((int'(ptr) + i) % N);
      if (!found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/sys_job_arbiter.sv
// Round-robin job scheduler in front of a shared matmul engine: accepts one
// descriptor per handshake, programs and starts the engine, reports completion.
module sys_job_arbiter
  import sys_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*3*LEN_W-1:0]    req_desc,
  output logic [LEN_W-1:0]              eng_stream_len,
  output logic [LEN_W-1:0]              eng_flush_len,
  output logic [LEN_W-1:0]              eng_tile_count,
  output logic                          eng_start,
  input  logic                          eng_busy,
  input  logic                          eng_done,
  output logic                          cmp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    cmp_id,
  output logic                          cmp_err,
  output logic [$clog2(NUM_REQ)-1:0]    owner_id,
  output logic                          sched_busy
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int DESC_W = DESC_FIELDS * LEN_W;
  localparam int WD_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W:0] WD_LIMIT = (WD_W + 1)'(TIMEOUT_CYCLES);

  sched_state_e      state_r, state_n_s;
  logic [ID_W-1:0]   rr_ptr_r, owner_s, owner_id_r, cmp_id_r;
  logic [NUM_REQ-1:0] grant_s;
  logic              accept_s, err_n_s, wd_hit_s;
  logic [DESC_W-1:0] desc_sel_s;
  logic [WD_W-1:0]   wd_r;
  logic [LEN_W-1:0]  stream_r, flush_r, tile_r;
  logic              eng_start_r, cmp_valid_r, cmp_err_r, sched_busy_r;

  function automatic logic [LEN_W-1:0] subst_len(input logic [LEN_W-1:0] v, input int dflt);
    return (v == {LEN_W{1'b0}}) ? LEN_W'(dflt) : v;
  endfunction

  rr_arbiter #(.N(NUM_REQ), .PTR_W(ID_W)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (grant_s)
  );

  // Ready is only offered while idle; encode the grant into an owner index.
  always_comb begin
    owner_s = {ID_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_s = grant_s[i] ? ID_W'(i) : owner_s;
    end
    if (state_r == ST_IDLE) begin
      req_ready = grant_s;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  assign accept_s   = |(req_valid & req_ready);
  assign desc_sel_s = req_desc[int'(owner_s) * DESC_W +: DESC_W];

  // Count reaching the limit on this cycle's increment: completes exactly
  // TIMEOUT_CYCLES clocks after WAIT_ACK entry.
  assign wd_hit_s = (TIMEOUT_CYCLES > 0) &&
                    (({1'b0, wd_r} + (WD_W + 1)'(1)) == WD_LIMIT);

  // Next-state logic; a done in the same cycle as expiry wins with err=0.
  always_comb begin
    state_n_s = state_r;
    err_n_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_n_s = ST_ISSUE;
        else          state_n_s = ST_IDLE;
      end
      ST_ISSUE: state_n_s = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (eng_busy) begin
          state_n_s = ST_WAIT_DONE;
        end else if (wd_hit_s) begin
          state_n_s = ST_COMPLETE;
          err_n_s   = 1'b1;
        end else begin
          state_n_s = ST_WAIT_ACK;
        end
      end
      ST_WAIT_DONE: begin
        if (eng_done && !eng_busy) begin
          state_n_s = ST_COMPLETE;
        end else if (wd_hit_s) begin
          state_n_s = ST_COMPLETE;
          err_n_s   = 1'b1;
        end else begin
          state_n_s = ST_WAIT_DONE;
        end
      end
      ST_COMPLETE: state_n_s = ST_IDLE;
      default:     state_n_s = ST_IDLE;
    endcase
  end

  // State register, registered status pulses and saturating watchdog.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_r      <= ST_IDLE;
      eng_start_r  <= 1'b0;
      cmp_valid_r  <= 1'b0;
      cmp_err_r    <= 1'b0;
      sched_busy_r <= 1'b0;
      wd_r         <= {WD_W{1'b0}};
    end else begin
      state_r      <= state_n_s;
      eng_start_r  <= (state_n_s == ST_ISSUE);
      cmp_valid_r  <= (state_n_s == ST_COMPLETE);
      cmp_err_r    <= (state_n_s == ST_COMPLETE) && err_n_s;
      sched_busy_r <= (state_n_s != ST_IDLE);
      if (state_r == ST_ISSUE) begin
        wd_r <= {WD_W{1'b0}};
      end else if ((state_r == ST_WAIT_ACK || state_r == ST_WAIT_DONE) &&
                   (wd_r != {WD_W{1'b1}})) begin
        wd_r <= wd_r + WD_W'(1);
      end
    end
  end

  // Job latch: owner, round-robin pointer and engine configuration.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      rr_ptr_r   <= {ID_W{1'b0}};
      owner_id_r <= {ID_W{1'b0}};
      cmp_id_r   <= {ID_W{1'b0}};
      stream_r   <= LEN_W'(DEF_STREAM_LEN);
      flush_r    <= LEN_W'(DEF_FLUSH_LEN);
      tile_r     <= LEN_W'(DEF_TILE_COUNT);
    end else begin
      if (accept_s) begin
        owner_id_r <= owner_s;
        rr_ptr_r   <= (owner_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : owner_s + ID_W'(1);
        stream_r   <= subst_len(desc_sel_s[DESC_STREAM_OFS*LEN_W +: LEN_W], DEF_STREAM_LEN);
        flush_r    <= subst_len(desc_sel_s[DESC_FLUSH_OFS*LEN_W  +: LEN_W], DEF_FLUSH_LEN);
        tile_r     <= subst_len(desc_sel_s[DESC_TILE_OFS*LEN_W   +: LEN_W], DEF_TILE_COUNT);
      end
      if (state_n_s == ST_COMPLETE) begin
        cmp_id_r <= owner_id_r;
      end
    end
  end

  assign eng_stream_len = stream_r;
  assign eng_flush_len  = flush_r;
  assign eng_tile_count = tile_r;
  assign eng_start      = eng_start_r;
  assign cmp_valid      = cmp_valid_r;
  assign cmp_err        = cmp_err_r;
  assign cmp_id         = cmp_id_r;
  assign owner_id       = owner_id_r;
  assign sched_busy     = sched_busy_r;

endmodule

// File: tb/tb_sys_job_arbiter.sv
// Directed bench for sys_job_arbiter: single job, descriptor defaults, fairness,
// watchdog, stale done and mid-job reset, with hand-computed expectations.
module tb_sys_job_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LEN_W   = 16;
  localparam int TMO     = 100;

  logic                       s_axi_aclk;
  logic                       s_axi_aresetn;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*3*LEN_W-1:0] req_desc;
  logic [LEN_W-1:0]           eng_stream_len, eng_flush_len, eng_tile_count;
  logic                       eng_start, eng_busy, eng_done;
  logic                       cmp_valid, cmp_err, sched_busy;
  logic [1:0]                 cmp_id, owner_id;

  int checks = 0;
  int errors = 0;

  sys_job_arbiter #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .TIMEOUT_CYCLES(TMO)) dut (
    .s_axi_aclk     (s_axi_aclk),
    .s_axi_aresetn  (s_axi_aresetn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_desc       (req_desc),
    .eng_stream_len (eng_stream_len),
    .eng_flush_len  (eng_flush_len),
    .eng_tile_count (eng_tile_count),
    .eng_start      (eng_start),
    .eng_busy       (eng_busy),
    .eng_done       (eng_done),
    .cmp_valid      (cmp_valid),
    .cmp_id         (cmp_id),
    .cmp_err        (cmp_err),
    .owner_id       (owner_id),
    .sched_busy     (sched_busy)
  );

  initial begin
    s_axi_aclk = 1'b0;
    forever #5 s_axi_aclk = ~s_axi_aclk;
  end

  task automatic set_desc(input int i, input logic [15:0] tile, input logic [15:0] flush,
                          input logic [15:0] stream);
    req_desc[i*48 +: 48] = {tile, flush, stream};
  endtask

  task automatic check_lens(input string name, input logic [15:0] s, input logic [15:0] f,
                            input logic [15:0] t);
    checks++;
    if (eng_stream_len !== s || eng_flush_len !== f || eng_tile_count !== t) begin
      errors++;
      $display("FAIL %s: got %0d/%0d/%0d want %0d/%0d/%0d", name,
               eng_stream_len, eng_flush_len, eng_tile_count, s, f, t);
    end
  endtask

  // Called at a negedge while idle; returns at the WAIT_ACK-entry negedge.
  task automatic accept_job(input logic [3:0] valids, input logic [3:0] exp_grant,
                            input int exp_owner, input bit keep);
    req_valid = valids;
    #1;
    checks++;
    if (req_ready !== exp_grant) begin
      errors++;
      $display("FAIL grant: req_ready=%b want %b", req_ready, exp_grant);
    end
    @(negedge s_axi_aclk);
    if (!keep) req_valid = 4'b0000;
    checks++;
    if (eng_start !== 1'b1 || owner_id !== 2'(exp_owner) || sched_busy !== 1'b1) begin
      errors++;
      $display("FAIL issue: start=%b owner=%0d busy=%b want 1/%0d/1",
               eng_start, owner_id, sched_busy, exp_owner);
    end
    @(negedge s_axi_aclk);
    checks++;
    if (eng_start !== 1'b0) begin
      errors++;
      $display("FAIL start_pulse: eng_start=%b want 0", eng_start);
    end
  endtask

  // Engine model: ack after ack_delay cycles, busy for busy_cycles, then done.
  task automatic run_engine(input int exp_id, input int ack_delay, input int busy_cycles);
    bit early;
    early = 1'b0;
    repeat (ack_delay) begin
      @(negedge s_axi_aclk);
      if (cmp_valid !== 1'b0 || req_ready !== 4'b0000) early = 1'b1;
    end
    eng_busy = 1'b1;
    eng_done = 1'b0;
    repeat (busy_cycles) begin
      @(negedge s_axi_aclk);
      if (cmp_valid !== 1'b0 || req_ready !== 4'b0000) early = 1'b1;
    end
    eng_busy = 1'b0;
    eng_done = 1'b1;
    checks++;
    if (early) begin
      errors++;
      $display("FAIL early_cmp: completion or ready seen while engine running");
    end
    @(negedge s_axi_aclk);
    #1;
    checks++;
    if (cmp_valid !== 1'b1 || cmp_id !== 2'(exp_id) || cmp_err !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL completion: valid=%b id=%0d err=%b ready=%b want 1/%0d/0/0000",
               cmp_valid, cmp_id, cmp_err, req_ready, exp_id);
    end
    @(negedge s_axi_aclk);
    checks++;
    if (cmp_valid !== 1'b0 || sched_busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: cmp_valid=%b sched_busy=%b want 0/0", cmp_valid, sched_busy);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    #1;
    checks++;
    if (req_ready !== 4'b0000 || eng_start !== 1'b0 || cmp_valid !== 1'b0 || cmp_err !== 1'b0 ||
        cmp_id !== 2'd0 || owner_id !== 2'd0 || sched_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: ready=%b start=%b cv=%b ce=%b cid=%0d own=%0d busy=%b want all 0",
               name, req_ready, eng_start, cmp_valid, cmp_err, cmp_id, owner_id, sched_busy);
    end
    check_lens({name, "_lens"}, 16'd8, 16'd8, 16'd1);
  endtask

  task automatic test_reset();
    s_axi_aresetn = 1'b0;
    req_valid     = 4'b0000;
    eng_busy      = 1'b0;
    eng_done      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_desc(i, 16'h0111 * 16'(i + 1), 16'h0222, 16'h0333);
    repeat (3) @(negedge s_axi_aclk);
    check_reset_outputs("reset");
    s_axi_aresetn = 1'b1;
    @(negedge s_axi_aclk);
  endtask

  task automatic test_single_job();
    set_desc(2, 16'd1, 16'd8, 16'd8);
    accept_job(4'b0111 & 4'b0100, 4'b0100, 2, 1'b0);
    check_lens("single_lens", 16'd8, 16'd8, 16'd1);
    run_engine(2, 0, 30);
  endtask

  task automatic test_zero_desc();
    set_desc(1, 16'd3, 16'd20, 16'd100);
    accept_job(4'b0010, 4'b0010, 1, 1'b0);
    check_lens("nonzero_lens", 16'd100, 16'd20, 16'd3);
    run_engine(1, 0, 2);
    set_desc(3, 16'd0, 16'd0, 16'd0);
    accept_job(4'b1000, 4'b1000, 3, 1'b0);
    check_lens("zero_desc_lens", 16'd8, 16'd8, 16'd1);
    run_engine(3, 0, 2);
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    for (int j = 0; j < 8; j++) begin
      exp_g = 4'b0001 << (j % 4);
      accept_job(4'b1111, exp_g, j % 4, 1'b1);
      run_engine(j % 4, 0, 3);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_timeout();
    bit early;
    early    = 1'b0;
    eng_busy = 1'b0;
    eng_done = 1'b0;
    accept_job(4'b0010, 4'b0010, 1, 1'b0);
    for (int k = 1; k < TMO; k++) begin
      @(negedge s_axi_aclk);
      if (cmp_valid !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL timeout_early: cmp_valid before %0d cycles", TMO);
    end
    @(negedge s_axi_aclk);
    checks++;
    if (cmp_valid !== 1'b1 || cmp_err !== 1'b1 || cmp_id !== 2'd1) begin
      errors++;
      $display("FAIL timeout_cmp: valid=%b err=%b id=%0d want 1/1/1", cmp_valid, cmp_err, cmp_id);
    end
    @(negedge s_axi_aclk);
    checks++;
    if (cmp_err !== 1'b0 || sched_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: err=%b busy=%b want 0/0", cmp_err, sched_busy);
    end
    accept_job(4'b0100, 4'b0100, 2, 1'b0);
    run_engine(2, 0, 3);
  endtask

  task automatic test_stale_done();
    eng_done = 1'b1;
    accept_job(4'b1000, 4'b1000, 3, 1'b0);
    run_engine(3, 5, 4);
  endtask

  task automatic test_reset_mid_job();
    set_desc(2, 16'd2, 16'd9, 16'd9);
    accept_job(4'b0100, 4'b0100, 2, 1'b0);
    eng_busy = 1'b1;
    eng_done = 1'b0;
    repeat (3) @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b0;
    eng_busy      = 1'b0;
    eng_done      = 1'b1;
    @(negedge s_axi_aclk);
    check_reset_outputs("reset_mid");
    s_axi_aresetn = 1'b1;
    eng_done      = 1'b0;
    @(negedge s_axi_aclk);
    checks++;
    if (cmp_valid !== 1'b0 || sched_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_cmp: cmp_valid=%b busy=%b want 0/0", cmp_valid, sched_busy);
    end
    accept_job(4'b1111, 4'b0001, 0, 1'b0);
    run_engine(0, 0, 2);
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_zero_desc();
    test_fairness();
    test_timeout();
    test_stale_done();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
